// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - VGA pin receiver: locks to sync timing and streams active pixels
// Define VGA_CAP_CRC_EN to add a per-frame CRC-16-CCITT on o_frame_crc.
module vga_frame_capture #(
  parameter int COL_BITS = 4,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  localparam int RW = $clog2(HEIGHT),
  localparam int CW = $clog2(WIDTH),
  localparam int PW = 3 * COL_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_hsync,
  input  logic                i_vsync,
  input  logic [COL_BITS-1:0] i_r,
  input  logic [COL_BITS-1:0] i_g,
  input  logic [COL_BITS-1:0] i_b,
  output logic                o_pix_valid,
  output logic [RW-1:0]       o_pix_row,
  output logic [CW-1:0]       o_pix_col,
  output logic [PW-1:0]       o_pix_rgb,
  output logic                o_frame_done,
  output logic                o_locked,
  output logic                o_err_line,
  output logic [15:0]         o_frame_crc
);
  localparam int HW        = $clog2(H_TOTAL + 1);
  localparam int LW        = $clog2(V_BP + 1);
  localparam int PIX_START = H_SYNC + H_BP;
  localparam int PIX_END   = PIX_START + WIDTH;

  typedef enum logic [2:0] {SEEK, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t        state;
  logic          hs_s, hs_d, vs_s, vs_d;
  logic [PW-1:0] rgb_s;
  logic [HW-1:0] hcnt, hpos;
  logic [LW-1:0] line_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col;
  logic          last_q, gated_q;
  logic          hs_edge, vs_on, vs_edge, go_vsync, line_bad, pix_act, last_pix;

  // hpos is the horizontal position of the sample now held in the sync stage
  always_comb begin
    hs_edge  = (hs_s == SYNC_POL) && (hs_d != SYNC_POL);
    vs_on    = (vs_s == SYNC_POL);
    vs_edge  = vs_on && (vs_d != SYNC_POL);
    if (hs_edge)                    hpos = '0;
    else if (hcnt == HW'(H_TOTAL))  hpos = hcnt;
    else                            hpos = hcnt + 1'b1;
    col      = CW'(32'(hpos) - PIX_START);
    pix_act  = (state == ACTIVE) && (32'(hpos) >= PIX_START) && (32'(hpos) < PIX_END);
    last_pix = pix_act && (row_q == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));
    line_bad = hs_edge && (32'(hcnt) + 32'd1 != 32'(H_TOTAL));
    go_vsync = vs_edge && (state inside {SEEK, ACTIVE, VFP});
  end

`ifdef VGA_CAP_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [PW-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = PW - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`else
  assign o_frame_crc = 16'h0000;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_s         <= ~SYNC_POL;
      hs_d         <= ~SYNC_POL;
      vs_s         <= ~SYNC_POL;
      vs_d         <= ~SYNC_POL;
      rgb_s        <= '0;
      hcnt         <= '0;
      line_q       <= '0;
      row_q        <= '0;
      state        <= SEEK;
      last_q       <= 1'b0;
      gated_q      <= 1'b0;
      o_pix_valid  <= 1'b0;
      o_pix_row    <= '0;
      o_pix_col    <= '0;
      o_pix_rgb    <= '0;
      o_frame_done <= 1'b0;
      o_locked     <= 1'b0;
      o_err_line   <= 1'b0;
`ifdef VGA_CAP_CRC_EN
      crc_q        <= 16'hFFFF;
      o_frame_crc  <= 16'h0000;
`endif
    end else begin
      hs_s         <= i_hsync;
      hs_d         <= hs_s;
      vs_s         <= i_vsync;
      vs_d         <= vs_s;
      rgb_s        <= {i_r, i_g, i_b};
      hcnt         <= hpos;
      o_pix_valid  <= pix_act && i_en;
      o_frame_done <= last_q;
      // a frame with any gated pixel is not reported as done
      last_q       <= last_pix && i_en && !gated_q && !go_vsync;
      if (pix_act && i_en) begin
        o_pix_row <= row_q;
        o_pix_col <= col;
        o_pix_rgb <= rgb_s;
      end
      if (pix_act && !i_en) gated_q <= 1'b1;
`ifdef VGA_CAP_CRC_EN
      if (pix_act && i_en) crc_q <= crc_step(crc_q, rgb_s);
      if (last_q) o_frame_crc <= crc_q;
      if (go_vsync) crc_q <= 16'hFFFF;
`endif
      if (go_vsync) begin
        state   <= VSYNC;
        gated_q <= 1'b0;
        if (state == ACTIVE) begin
          o_err_line <= 1'b1;
          o_locked   <= 1'b0;
        end
      end else if (o_locked && line_bad) begin
        state      <= SEEK;
        o_err_line <= 1'b1;
        o_locked   <= 1'b0;
      end else begin
        case (state)
          VSYNC: if (!vs_on) begin
            state  <= VBP;
            line_q <= '0;
          end
          VBP: if (hs_edge) begin
            if (32'(line_q) == V_BP - 1) begin
              state    <= ACTIVE;
              row_q    <= '0;
              o_locked <= 1'b1;
            end else begin
              line_q <= line_q + 1'b1;
            end
          end
          ACTIVE: begin
            if (hs_edge) row_q <= row_q + 1'b1;
            if (last_pix) state <= VFP;
          end
          SEEK, VFP: ;
          default: state <= SEEK;
        endcase
      end
    end
  end
endmodule
